// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB full-speed packet constants, encodings and RX state enum
// Contents:
//   SYNC_BYTE, PID_* : on-the-wire byte values (bit 0 first on the wire)
//   rx_packet_t      : 3-bit packet type reported on rx_packet
//   rx_state_t       : receive controller state encoding
//   pid_decode()     : PID byte -> packet type, PKT_NONE when not a legal PID
package usb_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_OUT   = 3'd1,
        PKT_IN    = 3'd2,
        PKT_DATA0 = 3'd3,
        PKT_DATA1 = 3'd4,
        PKT_ACK   = 3'd5,
        PKT_NAK   = 3'd6,
        PKT_STALL = 3'd7
    } rx_packet_t;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SYNC     = 4'd1,
        ST_PID      = 4'd2,
        ST_TOKEN1   = 4'd3,
        ST_TOKEN2   = 4'd4,
        ST_WAIT_EOP = 4'd5,
        ST_DATA     = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERROR    = 4'd8
    } rx_state_t;

    // The upper nibble must be the ones-complement of the lower nibble; the
    // explicit match list then rejects reserved/unsupported PIDs.
    function automatic rx_packet_t pid_decode(input logic [7:0] b);
        rx_packet_t p;
        p = PKT_NONE;
        if (b[7:4] == ~b[3:0]) begin
            case (b)
                PID_OUT:   p = PKT_OUT;
                PID_IN:    p = PKT_IN;
                PID_DATA0: p = PKT_DATA0;
                PID_DATA1: p = PKT_DATA1;
                PID_ACK:   p = PKT_ACK;
                PID_NAK:   p = PKT_NAK;
                PID_STALL: p = PKT_STALL;
                default:   p = PKT_NONE;
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/usb_rx_controller_if.sv
// rtl/usb_rx_controller_if.sv - signal bundle between RX byte source, CRC checkers, RX FIFO and the RX controller
// Modports:
//   slave  : the RX controller (consumes line/FIFO status, drives CRC/FIFO/status)
//   master : the surrounding logic or a testbench driving the controller
interface usb_rx_controller_if #(
    parameter int CNT_W = 7
);
    logic             start_detect;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             eop;
    logic             crc5_ok;
    logic             crc16_ok;
    logic             fifo_full;
    logic             crc_clear;
    logic             crc_en;
    logic             fifo_wen;
    logic [7:0]       fifo_wdata;
    logic [2:0]       rx_packet;
    logic             rx_data_ready;
    logic             rx_transfer_active;
    logic             rx_error;
    logic [CNT_W-1:0] payload_count;

    modport slave (
        input  start_detect, rx_byte, byte_valid, eop, crc5_ok, crc16_ok, fifo_full,
        output crc_clear, crc_en, fifo_wen, fifo_wdata, rx_packet, rx_data_ready,
               rx_transfer_active, rx_error, payload_count
    );

    modport master (
        output start_detect, rx_byte, byte_valid, eop, crc5_ok, crc16_ok, fifo_full,
        input  crc_clear, crc_en, fifo_wen, fifo_wdata, rx_packet, rx_data_ready,
               rx_transfer_active, rx_error, payload_count
    );
endinterface

// File: rtl/usb_rx_hold2.sv
// rtl/usb_rx_hold2.sv - two-byte delay line that withholds the trailing CRC16 bytes of a DATA packet
// Ports:
//   clk, n_rst     : clock, synchronous active-high reset
//   push, din      : accept a byte
//   flush          : empty the line (start of a new packet)
//   full           : two bytes held; the next push releases the oldest
//   out_valid, out : released byte, registered (one cycle after push)
module usb_rx_hold2 (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       push,
    input  logic       flush,
    input  logic [7:0] din,
    output logic       full,
    output logic       out_valid,
    output logic [7:0] out
);
    logic [7:0] h0;
    logic [7:0] h1;
    logic [1:0] cnt;

    assign full = (cnt == 2'd2);

    always_ff @(posedge clk) begin
        if (n_rst) begin
            h0        <= 8'h00;
            h1        <= 8'h00;
            cnt       <= 2'd0;
            out_valid <= 1'b0;
            out       <= 8'h00;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                cnt <= 2'd0;
            end else if (push) begin
                case (cnt)
                    2'd0: begin
                        h0  <= din;
                        cnt <= 2'd1;
                    end
                    2'd1: begin
                        h1  <= din;
                        cnt <= 2'd2;
                    end
                    default: begin
                        // Oldest byte is now known not to be CRC: release it.
                        out       <= h0;
                        out_valid <= 1'b1;
                        h0        <= h1;
                        h1        <= din;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/usb_rx_controller.sv
// rtl/usb_rx_controller.sv - USB full-speed receive packet controller (SYNC/PID check, token/data/handshake sequencing)
// Ports:
//   clk   : system clock
//   n_rst : synchronous reset, active-high
//   bus   : usb_rx_controller_if.slave
//           in : start_detect, rx_byte, byte_valid, eop, crc5_ok, crc16_ok, fifo_full
//           out: crc_clear, crc_en, fifo_wen, fifo_wdata, rx_packet, rx_data_ready,
//                rx_transfer_active, rx_error, payload_count
module usb_rx_controller
    import usb_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64,
    parameter int CNT_W       = 7
) (
    input  logic                 clk,
    input  logic                 n_rst,
    usb_rx_controller_if.slave   bus
);
    rx_state_t        state_q;
    rx_state_t        state_d;
    rx_packet_t       rx_packet_q;
    rx_packet_t       pid_pkt;
    logic [CNT_W-1:0] count_q;
    logic             rx_error_q;
    logic             data_ready_q;

    logic crc_clear;
    logic crc_en;
    logic hold_push;
    logic hold_flush;
    logic hold_full;
    logic hold_out_valid;
    logic [7:0] hold_out;
    logic err_clr;
    logic data_ok;
    logic pkt_load;
    logic cnt_inc;
    logic is_token;

    usb_rx_hold2 u_hold (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (hold_push),
        .flush     (hold_flush),
        .din       (bus.rx_byte),
        .full      (hold_full),
        .out_valid (hold_out_valid),
        .out       (hold_out)
    );

    assign pid_pkt  = pid_decode(bus.rx_byte);
    assign is_token = (rx_packet_q == PKT_OUT) || (rx_packet_q == PKT_IN);

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q      <= ST_IDLE;
            rx_packet_q  <= PKT_NONE;
            count_q      <= '0;
            rx_error_q   <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_ready_q <= data_ok;
            if (pkt_load) begin
                rx_packet_q <= pid_pkt;
            end
            if (hold_flush) begin
                count_q <= '0;
            end else if (cnt_inc) begin
                count_q <= count_q + 1'b1;
            end
            if (state_d == ST_ERROR) begin
                rx_error_q <= 1'b1;
            end else if (err_clr) begin
                rx_error_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        crc_clear  = 1'b0;
        crc_en     = 1'b0;
        hold_push  = 1'b0;
        hold_flush = 1'b0;
        err_clr    = 1'b0;
        data_ok    = 1'b0;
        pkt_load   = 1'b0;
        cnt_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_detect) begin
                    state_d = ST_SYNC;
                    err_clr = 1'b1;
                end
            end

            ST_SYNC: begin
                if (bus.eop || (bus.byte_valid && bus.rx_byte != SYNC_BYTE)) begin
                    state_d = ST_ERROR;
                end else if (bus.byte_valid) begin
                    state_d = ST_PID;
                end
            end

            ST_PID: begin
                if (bus.eop) begin
                    state_d = ST_ERROR;
                end else if (bus.byte_valid) begin
                    if (pid_pkt == PKT_NONE) begin
                        state_d = ST_ERROR;
                    end else begin
                        pkt_load   = 1'b1;
                        crc_clear  = 1'b1;
                        hold_flush = 1'b1;
                        case (pid_pkt)
                            PKT_OUT, PKT_IN:     state_d = ST_TOKEN1;
                            PKT_DATA0, PKT_DATA1: state_d = ST_DATA;
                            default:             state_d = ST_WAIT_EOP;
                        endcase
                    end
                end
            end

            ST_TOKEN1, ST_TOKEN2: begin
                if (bus.eop) begin
                    state_d = ST_ERROR;
                end else if (bus.byte_valid) begin
                    crc_en  = 1'b1;
                    state_d = (state_q == ST_TOKEN1) ? ST_TOKEN2 : ST_WAIT_EOP;
                end
            end

            ST_WAIT_EOP: begin
                if (bus.byte_valid) begin
                    state_d = ST_ERROR;
                end else if (bus.eop) begin
                    state_d = (is_token && !bus.crc5_ok) ? ST_ERROR : ST_DONE;
                end
            end

            ST_DATA: begin
                if (bus.byte_valid && bus.eop) begin
                    state_d = ST_ERROR;
                end else if (bus.eop) begin
                    // A full hold means both CRC16 bytes have arrived.
                    if (hold_full && bus.crc16_ok) begin
                        data_ok = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else if (bus.byte_valid) begin
                    crc_en = 1'b1;
                    if (hold_full &&
                        (bus.fifo_full || count_q == CNT_W'(MAX_PAYLOAD))) begin
                        state_d = ST_ERROR;
                    end else begin
                        hold_push = 1'b1;
                        cnt_inc   = hold_full;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            ST_ERROR: begin
                if (bus.start_detect) begin
                    state_d = ST_SYNC;
                    err_clr = 1'b1;
                end else if (bus.eop) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.crc_clear          = crc_clear;
    assign bus.crc_en             = crc_en;
    assign bus.fifo_wen           = hold_out_valid;
    assign bus.fifo_wdata         = hold_out;
    assign bus.rx_packet          = rx_packet_q;
    assign bus.rx_data_ready      = data_ready_q;
    assign bus.rx_transfer_active = (state_q == ST_PID)    || (state_q == ST_TOKEN1) ||
                                    (state_q == ST_TOKEN2) || (state_q == ST_WAIT_EOP) ||
                                    (state_q == ST_DATA);
    assign bus.rx_error           = rx_error_q;
    assign bus.payload_count      = count_q;
endmodule

// File: tb/tb_usb_rx_controller.sv
// tb/tb_usb_rx_controller.sv - directed self-checking bench for usb_rx_controller
module tb_usb_rx_controller;
    logic clk;
    logic n_rst;
    int   total;
    int   bad;
    int   rdy_cnt;
    logic [7:0] wq[$];

    usb_rx_controller_if #(.CNT_W(7)) bus ();

    usb_rx_controller #(.MAX_PAYLOAD(64), .CNT_W(7)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.fifo_wen) wq.push_back(bus.fifo_wdata);
        if (bus.rx_data_ready) rdy_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte    = b;
        bus.byte_valid = 1'b1;
        cyc();
        bus.byte_valid = 1'b0;
        cyc();
    endtask

    task automatic send_start();
        bus.start_detect = 1'b1;
        cyc();
        bus.start_detect = 1'b0;
        cyc();
    endtask

    task automatic send_eop(input logic c5, input logic c16);
        bus.eop      = 1'b1;
        bus.crc5_ok  = c5;
        bus.crc16_ok = c16;
        cyc();
        bus.eop      = 1'b0;
        bus.crc5_ok  = 1'b0;
        bus.crc16_ok = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic clear_mon();
        wq.delete();
        rdy_cnt = 0;
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        repeat (2) cyc();
        n_rst = 1'b0;
        cyc();
        total++; if (bus.rx_packet !== 3'd0) begin bad++; $display("FAIL reset_rx_packet: got %0d want 0", bus.rx_packet); end
        total++; if (bus.rx_error !== 1'b0) begin bad++; $display("FAIL reset_rx_error: got %0b want 0", bus.rx_error); end
        total++; if (bus.rx_transfer_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %0b want 0", bus.rx_transfer_active); end
        total++; if (bus.fifo_wen !== 1'b0) begin bad++; $display("FAIL reset_fifo_wen: got %0b want 0", bus.fifo_wen); end
        total++; if (bus.payload_count !== 7'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.payload_count); end
        total++; if (bus.rx_data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", bus.rx_data_ready); end
    endtask

    task automatic test_data0();
        clear_mon();
        send_start();
        bus.rx_byte = 8'h80; bus.byte_valid = 1'b1; cyc(); bus.byte_valid = 1'b0;
        total++; if (bus.rx_transfer_active !== 1'b1) begin bad++; $display("FAIL data0_active: got %0b want 1", bus.rx_transfer_active); end
        cyc();
        bus.rx_byte = 8'hC3; bus.byte_valid = 1'b1; #1;
        total++; if (bus.crc_clear !== 1'b1) begin bad++; $display("FAIL data0_crc_clear: got %0b want 1", bus.crc_clear); end
        cyc(); bus.byte_valid = 1'b0; cyc();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'hA5); send_byte(8'h5A);
        send_eop(1'b0, 1'b1);
        total++; if (wq.size() != 3) begin bad++; $display("FAIL data0_nwrites: got %0d want 3", wq.size()); end
        else begin
            total++; if (wq[0] !== 8'h11 || wq[1] !== 8'h22 || wq[2] !== 8'h33) begin
                bad++; $display("FAIL data0_wdata: got %h %h %h want 11 22 33", wq[0], wq[1], wq[2]);
            end
        end
        total++; if (bus.rx_packet !== 3'd3) begin bad++; $display("FAIL data0_pkt: got %0d want 3", bus.rx_packet); end
        total++; if (rdy_cnt != 1) begin bad++; $display("FAIL data0_ready: got %0d want 1", rdy_cnt); end
        total++; if (bus.payload_count !== 7'd3) begin bad++; $display("FAIL data0_count: got %0d want 3", bus.payload_count); end
        total++; if (bus.rx_error !== 1'b0 || bus.rx_transfer_active !== 1'b0) begin
            bad++; $display("FAIL data0_status: got err=%0b act=%0b want 0 0", bus.rx_error, bus.rx_transfer_active);
        end
    endtask

    task automatic test_in_token();
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            send_start();
            send_byte(8'h80); send_byte(8'h69);
            send_byte(8'h12); send_byte(8'h34);
            send_eop(k == 0, 1'b0);
            total++; if (bus.rx_packet !== 3'd2) begin bad++; $display("FAIL in_pkt%0d: got %0d want 2", k, bus.rx_packet); end
            total++; if (wq.size() != 0) begin bad++; $display("FAIL in_nowrite%0d: got %0d want 0", k, wq.size()); end
            total++; if (bus.rx_error !== (k == 1)) begin bad++; $display("FAIL in_error%0d: got %0b want %0b", k, bus.rx_error, k == 1); end
        end
    endtask

    task automatic test_bad_sync_pid();
        clear_mon();
        send_start();
        total++; if (bus.rx_error !== 1'b0) begin bad++; $display("FAIL start_clears_error: got %0b want 0", bus.rx_error); end
        send_byte(8'h00);
        total++; if (bus.rx_error !== 1'b1 || bus.rx_transfer_active !== 1'b0) begin
            bad++; $display("FAIL bad_sync: got err=%0b act=%0b want 1 0", bus.rx_error, bus.rx_transfer_active);
        end
        send_byte(8'hC3); send_byte(8'h55);
        send_eop(1'b1, 1'b1);
        total++; if (bus.rx_error !== 1'b1 || bus.rx_packet !== 3'd2) begin
            bad++; $display("FAIL bad_sync_ignore: got err=%0b pkt=%0d want 1 2", bus.rx_error, bus.rx_packet);
        end
        send_start();
        total++; if (bus.rx_error !== 1'b0) begin bad++; $display("FAIL err_clear: got %0b want 0", bus.rx_error); end
        send_byte(8'h80); send_byte(8'hE2);
        total++; if (bus.rx_error !== 1'b1) begin bad++; $display("FAIL bad_pid: got %0b want 1", bus.rx_error); end
        send_eop(1'b0, 1'b0);
        total++; if (wq.size() != 0) begin bad++; $display("FAIL bad_nowrite: got %0d want 0", wq.size()); end
    endtask

    task automatic test_overflow();
        int errs;
        clear_mon();
        send_start();
        send_byte(8'h80); send_byte(8'h4B);
        for (int i = 1; i <= 65; i++) send_byte(8'(i));
        send_byte(8'hEE); send_byte(8'hFF);
        send_eop(1'b0, 1'b1);
        total++; if (wq.size() != 64) begin bad++; $display("FAIL ovf_nwrites: got %0d want 64", wq.size()); end
        else begin
            errs = 0;
            for (int i = 0; i < 64; i++) if (wq[i] !== 8'(i + 1)) errs++;
            total++; if (errs != 0) begin bad++; $display("FAIL ovf_wdata: got %0d wrong bytes want 0", errs); end
        end
        total++; if (bus.rx_error !== 1'b1) begin bad++; $display("FAIL ovf_error: got %0b want 1", bus.rx_error); end
        total++; if (rdy_cnt != 0) begin bad++; $display("FAIL ovf_ready: got %0d want 0", rdy_cnt); end
        total++; if (bus.payload_count !== 7'd64) begin bad++; $display("FAIL ovf_count: got %0d want 64", bus.payload_count); end
    endtask

    task automatic test_fifo_full();
        clear_mon();
        send_start();
        send_byte(8'h80); send_byte(8'hC3);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        bus.fifo_full = 1'b1;
        send_byte(8'h05); send_byte(8'hAB); send_byte(8'hCD);
        send_eop(1'b0, 1'b1);
        bus.fifo_full = 1'b0;
        total++; if (wq.size() != 2) begin bad++; $display("FAIL full_nwrites: got %0d want 2", wq.size()); end
        else begin
            total++; if (wq[0] !== 8'h01 || wq[1] !== 8'h02) begin bad++; $display("FAIL full_wdata: got %h %h want 01 02", wq[0], wq[1]); end
        end
        total++; if (bus.rx_error !== 1'b1 || rdy_cnt != 0) begin
            bad++; $display("FAIL full_status: got err=%0b rdy=%0d want 1 0", bus.rx_error, rdy_cnt);
        end
    endtask

    task automatic test_zero_len_ack();
        clear_mon();
        send_start();
        send_byte(8'h80); send_byte(8'hC3);
        send_byte(8'h12); send_byte(8'h34);
        send_eop(1'b0, 1'b1);
        total++; if (rdy_cnt != 1) begin bad++; $display("FAIL zlp_ready: got %0d want 1", rdy_cnt); end
        total++; if (bus.payload_count !== 7'd0 || wq.size() != 0) begin
            bad++; $display("FAIL zlp_count: got cnt=%0d writes=%0d want 0 0", bus.payload_count, wq.size());
        end
        total++; if (bus.rx_error !== 1'b0) begin bad++; $display("FAIL zlp_error: got %0b want 0", bus.rx_error); end
        clear_mon();
        send_start();
        send_byte(8'h80); send_byte(8'hD2);
        send_eop(1'b0, 1'b0);
        total++; if (bus.rx_packet !== 3'd5) begin bad++; $display("FAIL ack_pkt: got %0d want 5", bus.rx_packet); end
        total++; if (bus.rx_error !== 1'b0 || bus.rx_transfer_active !== 1'b0 || rdy_cnt != 0) begin
            bad++; $display("FAIL ack_status: got err=%0b act=%0b rdy=%0d want 0 0 0", bus.rx_error, bus.rx_transfer_active, rdy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_start();
        send_byte(8'h80); send_byte(8'h4B);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        send_eop(1'b0, 1'b1);
        total++; if (bus.rx_packet !== 3'd4 || bus.payload_count !== 7'd1) begin
            bad++; $display("FAIL b2b_pkt: got pkt=%0d cnt=%0d want 4 1", bus.rx_packet, bus.payload_count);
        end
        total++; if (wq.size() != 1 || rdy_cnt != 1) begin
            bad++; $display("FAIL b2b_writes: got writes=%0d rdy=%0d want 1 1", wq.size(), rdy_cnt);
        end
        else begin
            total++; if (wq[0] !== 8'hAA) begin bad++; $display("FAIL b2b_wdata: got %h want aa", wq[0]); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rdy_cnt = 0;
        n_rst = 1'b1;
        bus.start_detect = 1'b0;
        bus.rx_byte      = 8'h00;
        bus.byte_valid   = 1'b0;
        bus.eop          = 1'b0;
        bus.crc5_ok      = 1'b0;
        bus.crc16_ok     = 1'b0;
        bus.fifo_full    = 1'b0;
        cyc();
        test_reset();
        test_data0();
        test_in_token();
        test_bad_sync_pid();
        test_overflow();
        test_fifo_full();
        test_zero_len_ack();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usb_rx_controller.md
Name: usb_rx_controller

Overview:
- Receive-side packet controller for the USB full-speed endpoint; counterpart of the TX controller.
- Takes de-stuffed, NRZI-decoded bytes from the RX shift register and validates SYNC and PID.
- Sequences token, data and handshake packets, streams data payload into the RX FIFO and withholds the trailing 2 CRC bytes.
- Flags completion or error to the AHB-Lite slave side. CRC5/CRC16 arithmetic lives in external checkers; this block only steers them.

Parameters:
- MAX_PAYLOAD, 64, maximum data-payload bytes per packet, excluding CRC16.
- CNT_W, 7, width of the payload byte counter; must satisfy 2^CNT_W > MAX_PAYLOAD+2.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset; synchronous, active-high (n_rst=1 at a clk edge resets).
- start_detect  input  1  one-cycle pulse: line left idle (first K transition seen).
- rx_byte  input  8  received byte, rx_byte[0] = first bit on the wire.
- byte_valid  input  1  one-cycle strobe; rx_byte is valid this cycle.
- eop  input  1  one-cycle pulse: SE0-SE0-J end of packet seen.
- crc5_ok  input  1  external CRC5 residue correct; sampled on eop.
- crc16_ok  input  1  external CRC16 residue correct; sampled on eop.
- fifo_full  input  1  RX FIFO cannot accept a write.
- crc_clear  output  1  one-cycle pulse: reset both CRC checkers.
- crc_en  output  1  one-cycle pulse: feed rx_byte to CRC checkers.
- fifo_wen  output  1  one-cycle write strobe to RX FIFO.
- fifo_wdata  output  8  payload byte to RX FIFO.
- rx_packet  output  3  decoded packet type, held until next PID.
- rx_data_ready  output  1  one-cycle pulse: good DATA packet complete.
- rx_transfer_active  output  1  high from SYNC acceptance until DONE or ERROR.
- rx_error  output  1  sticky error; cleared on next start_detect.
- payload_count  output  CNT_W  payload bytes written for the current packet.

Behaviour:
- Reset: state IDLE; all outputs 0; rx_packet=NONE; hold registers are empty.
- Packet codes on rx_packet: NONE=0, OUT=1, IN=2, DATA0=3, DATA1=4, ACK=5, NAK=6, STALL=7.
- PID bytes: OUT E1, IN 69, DATA0 C3, DATA1 4B, ACK D2, NAK 5A, STALL 1E. SYNC byte 80.
- A PID is valid only if rx_byte[7:4] == ~rx_byte[3:0] and the byte matches one of the listed PIDs.
- IDLE: start_detect -> SYNC. Clear rx_error.
- SYNC: byte_valid with 80 -> PID and rx_transfer_active=1. Any other byte, or eop -> ERROR.
- PID: byte_valid with a valid PID -> latch rx_packet, pulse crc_clear, then branch:
  - OUT or IN -> TOKEN1.
  - DATA0 or DATA1 -> DATA.
  - ACK, NAK or STALL -> WAIT_EOP.
  - Invalid PID or eop -> ERROR.
- TOKEN1/TOKEN2: each byte_valid pulses crc_en and advances TOKEN1->TOKEN2->WAIT_EOP. eop in either state -> ERROR.
- WAIT_EOP:
  - eop -> DONE; for a token, also require crc5_ok, else ERROR.
  - byte_valid -> ERROR.
- DATA pipeline: two-byte hold (h0, h1) with count 0..2.
  - Each byte_valid pulses crc_en.
  - When the hold is full, emit h0 on fifo_wdata with fifo_wen, shift h1->h0 and load rx_byte into h1, then increment payload_count.
  - The write appears 1 cycle after byte_valid.
  - The final 2 bytes (CRC16) are never written.
- DATA, eop received:
  - Hold full and crc16_ok -> pulse rx_data_ready the next cycle, then DONE.
  - Otherwise -> ERROR. Payload bytes already written stay in the FIFO.
- DATA overflow:
  - Write needed while fifo_full=1 -> no write, go to ERROR.
  - payload_count would exceed MAX_PAYLOAD -> ERROR.
- Zero-length DATA (PID, CRC, CRC, eop) is legal: rx_data_ready pulses with payload_count=0.
- byte_valid and eop in the same cycle -> ERROR; the byte is discarded.
- DONE: rx_transfer_active=0, return to IDLE on the next cycle.
- ERROR: rx_error=1 and rx_transfer_active=0. Ignore bytes until eop, then IDLE. A start_detect while in ERROR goes directly to SYNC.
- start_detect outside IDLE/ERROR is ignored.
- n_rst mid-packet: immediate IDLE on that edge, no further fifo_wen; FIFO flushing is the owner's job.

Decomposition:
- Shared package usb_pkg holds:
  - The PID byte constants and SYNC_BYTE.
  - The 3-bit rx_packet encoding typedef.
  - The RX state enum.
- The TX controller imports the same package.
- One sub-module: usb_rx_hold2, the 2-byte CRC-withholding delay line. It has push, flush, full and out ports and one-cycle write latency.

Test Plan:
- DATA0 with payload 11 22 33 + CRC, crc16_ok=1: fifo writes exactly 11,22,33 in order; rx_packet=3; rx_data_ready pulses once; payload_count=3.
- IN token (69, 2 bytes, eop) with crc5_ok=1: rx_packet=2, no fifo_wen, no error. Repeat with crc5_ok=0: rx_error=1.
- SYNC byte 00 or PID byte E2: ERROR; rx_error=1; bytes ignored until eop; the next start_detect clears rx_error.
- DATA1 with 65-byte payload (MAX_PAYLOAD=64): 64 writes, then rx_error=1 and no rx_data_ready.
- fifo_full asserted after the 2nd payload byte of a 5-byte DATA packet: exactly 2 writes; rx_error=1.
- Zero-length DATA0 (C3, CRC, CRC, eop): rx_data_ready pulses, payload_count=0. ACK (D2, eop): rx_packet=5, clean return to IDLE.
